urv_im_wb_bridge: RTL

URV_IM_WB_BRIDGE -- requirements
Module: urv_im_wb_bridge

---
 rtl/urv_im_pkg.sv | 23 ++
 rtl/urv_im_line_buf.sv | 67 ++++++
 rtl/urv_im_wb_bridge.sv | 119 +++++++++++
 3 files changed

// File: rtl/urv_im_pkg.sv
// Shared types and sizing for the instruction-fetch Wishbone bridge.
// URV_IM_PREFETCH_EN selects the two-entry buffer with next-word prefetch.
package urv_im_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } im_state_e;

    localparam int TAG_W = 30;

`ifdef URV_IM_PREFETCH_EN
    localparam int NUM_ENTRIES = 2;
`else
    localparam int NUM_ENTRIES = 1;
`endif

    function automatic logic [31:0] tag_to_addr(input logic [TAG_W-1:0] tag);
        return {tag, 2'b00};
    endfunction

endpackage

// File: rtl/urv_im_line_buf.sv
// Tagged instruction word buffer: hit compare, next-word probe, victim
// selection and flush. Entry count follows URV_IM_PREFETCH_EN via the package.
module urv_im_line_buf
    import urv_im_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    input  logic [TAG_W-1:0] probe_tag_i,
    input  logic             wr_en_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i,
    output logic             hit_o,
    output logic [31:0]      hit_data_o,
    output logic             probe_hit_o
);

    logic             valid_q [NUM_ENTRIES];
    logic [TAG_W-1:0] tag_q   [NUM_ENTRIES];
    logic [31:0]      data_q  [NUM_ENTRIES];
    int               victim;

    always_comb begin
        hit_o       = 1'b0;
        hit_data_o  = '0;
        probe_hit_o = 1'b0;
        victim      = 0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == lookup_tag_i) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[i];
            end
            if (valid_q[i] && tag_q[i] == probe_tag_i) begin
                probe_hit_o = 1'b1;
            end
        end
        // Lowest-numbered entry that does not hold the word being fetched now.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!(valid_q[i] && tag_q[i] == lookup_tag_i)) begin
                victim = i;
            end
        end
    end

    // Flush wins over a same-edge write so a racing response is dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (flush_i) begin
                    valid_q[i] <= 1'b0;
                end else if (wr_en_i && victim == i) begin
                    valid_q[i] <= 1'b1;
                    tag_q[i]   <= wr_tag_i;
                    data_q[i]  <= wr_data_i;
                end
            end
        end
    end

endmodule

// File: rtl/urv_im_wb_bridge.sv
// Instruction-memory to Wishbone B4 pipelined read bridge, one read in flight.
// URV_IM_PREFETCH_EN adds a second entry and speculative next-word reads.
module urv_im_wb_bridge
    import urv_im_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic        im_flush_i,
    output logic        im_fault_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i
);

    im_state_e        state_q, state_d;
    logic [31:0]      cur_addr_q;
    logic [31:0]      req_addr_q, req_addr_d;
    logic             discard_q, discard_d;
    logic             fault_q, fault_d;
    logic             hit, probe_hit, buf_wr;
    logic [31:0]      hit_data;
    logic [TAG_W-1:0] probe_tag;
    logic             unused_bits;

`ifdef URV_IM_PREFETCH_EN
    // A 30-bit tag increment wraps 0xFFFFFFFC to 0x00000000.
    assign probe_tag   = cur_addr_q[31:2] + {{(TAG_W-1){1'b0}}, 1'b1};
    assign unused_bits = ^cur_addr_q[1:0];
`else
    assign probe_tag   = '0;
    assign unused_bits = ^{cur_addr_q[1:0], probe_hit};
`endif

    urv_im_line_buf u_line_buf (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .flush_i      (im_flush_i),
        .lookup_tag_i (cur_addr_q[31:2]),
        .probe_tag_i  (probe_tag),
        .wr_en_i      (buf_wr),
        .wr_tag_i     (req_addr_q[31:2]),
        .wr_data_i    (wb_dat_i),
        .hit_o        (hit),
        .hit_data_o   (hit_data),
        .probe_hit_o  (probe_hit)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            req_addr_q <= '0;
            discard_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= im_addr_i;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            fault_q    <= fault_d;
        end
    end

    // discard_q marks an in-flight read whose data was invalidated by a flush.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        fault_d    = 1'b0;
        buf_wr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                discard_d = 1'b0;
                if (!hit) begin
                    req_addr_d = tag_to_addr(cur_addr_q[31:2]);
                    state_d    = ST_REQ;
                end
`ifdef URV_IM_PREFETCH_EN
                else if (!probe_hit) begin
                    req_addr_d = tag_to_addr(probe_tag);
                    state_d    = ST_REQ;
                end
`endif
            end
            ST_REQ: begin
                discard_d = discard_q | im_flush_i;
                if (!wb_stall_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                discard_d = discard_q | im_flush_i;
                if (wb_ack_i) begin
                    buf_wr  = !discard_q;
                    state_d = ST_IDLE;
                end else if (wb_err_i) begin
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wb_cyc_o   = (state_q != ST_IDLE);
    assign wb_stb_o   = (state_q == ST_REQ);
    assign wb_adr_o   = req_addr_q;
    assign im_valid_o = hit;
    assign im_data_o  = hit_data;
    assign im_fault_o = fault_q;

endmodule
